// File: rtl/perceptron_host_pkg.sv
// Shared definitions for the perceptron host sequencer.
//   host_state_t : host sequencer states
//   SEL_*        : p_sel_out encodings understood by the perceptron core
//   ONE          : 1.0 in Q3.3
//   is_watched() : states where the host waits on the core and can time out
package perceptron_host_pkg;

  typedef enum logic [3:0] {
    IDLE, LD_W0, LD_W1, LD_W2, LD_N, SX1, SX2, WAIT_DONE,
    RD_W0, RD_W1, RD_W2, FINISH, ERR
  } host_state_t;

  localparam logic [1:0] SEL_W0  = 2'd3;
  localparam logic [1:0] SEL_W1  = 2'd2;
  localparam logic [1:0] SEL_W2  = 2'd1;
  localparam logic [1:0] SEL_SUM = 2'd0;

  localparam logic [5:0] ONE = 6'b001000;

  function automatic logic is_watched(host_state_t s);
    return (s == LD_W0) || (s == LD_W1) || (s == LD_W2) || (s == LD_N) ||
           (s == SX1) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/perceptron_host_if.sv
// Load/train bus between the host sequencer (master) and the perceptron
// core (slave).
//   master drives : p_go, p_update, p_correct, p_sel_out, p_in_val
//   slave drives  : p_done, p_class, p_sync, p_out_val
interface perceptron_host_if;
  import perceptron_host_pkg::*;

  logic       p_go;
  logic       p_update;
  logic       p_correct;
  logic [1:0] p_sel_out;
  logic [5:0] p_in_val;
  logic       p_done;
  logic       p_class;
  logic       p_sync;
  logic [5:0] p_out_val;

  modport master (
    output p_go, p_update, p_correct, p_sel_out, p_in_val,
    input  p_done, p_class, p_sync, p_out_val
  );

  modport slave (
    input  p_go, p_update, p_correct, p_sel_out, p_in_val,
    output p_done, p_class, p_sync, p_out_val
  );
endinterface

// File: rtl/perceptron_host_sample_mem.sv
// Training sample table: MAX_SAMPLES entries of {x1, x2, label}.
// Synchronous write, combinational read, contents are not reset.
//   clk                          : clock
//   wr_en/wr_addr/wr_x1/wr_x2/wr_label : write port
//   rd_addr -> rd_x1/rd_x2/rd_label    : asynchronous read port
module perceptron_sample_mem #(
  parameter int MAX_SAMPLES = 8,
  localparam int AW = $clog2(MAX_SAMPLES)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_x1,
  input  logic [5:0]    wr_x2,
  input  logic          wr_label,
  input  logic [AW-1:0] rd_addr,
  output logic [5:0]    rd_x1,
  output logic [5:0]    rd_x2,
  output logic          rd_label
);
  logic [12:0] mem [MAX_SAMPLES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_x1, wr_x2, wr_label};
  end

  assign {rd_x1, rd_x2, rd_label} = mem[rd_addr];
endmodule

// File: rtl/perceptron_host.sv
// Initiator-side sequencer for the perceptron load/train interface: loads
// initial weights and learning rate, runs num_epochs passes over the local
// sample table counting misclassifications, then reads the weights back.
// Ports:
//   clk, reset_l (async, active-low)
//   start, w0_init/w1_init/w2_init/n_rate, num_samples, num_epochs : run control
//   wr_en/wr_addr/wr_x1/wr_x2/wr_label : sample table write (ignored while busy)
//   busy, run_done, err, epoch_errs, w0_out/w1_out/w2_out        : status/results
//   converged : only with PERCEPTRON_HOST_EARLY_STOP_EN (stop once an epoch is error-free)
//   p : perceptron_host_if.master bus to the core
module perceptron_host
  import perceptron_host_pkg::*;
#(
  parameter int MAX_SAMPLES = 8,
  parameter int EPOCH_W     = 4,
  parameter int TIMEOUT     = 64,
  localparam int AW = $clog2(MAX_SAMPLES),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               start,
  input  logic [5:0]         w0_init,
  input  logic [5:0]         w1_init,
  input  logic [5:0]         w2_init,
  input  logic [5:0]         n_rate,
  input  logic [CW-1:0]      num_samples,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [5:0]         wr_x1,
  input  logic [5:0]         wr_x2,
  input  logic               wr_label,
  output logic               busy,
  output logic               run_done,
  output logic               err,
  output logic [CW-1:0]      epoch_errs,
  output logic [5:0]         w0_out,
  output logic [5:0]         w1_out,
  output logic [5:0]         w2_out,
`ifdef PERCEPTRON_HOST_EARLY_STOP_EN
  output logic               converged,
`endif
  perceptron_host_if.master  p
);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  host_state_t        state_reg, state_next;
  logic               loaded_reg, loaded_next;
  logic [AW-1:0]      idx_reg, idx_next;
  logic [EPOCH_W-1:0] epoch_reg, epoch_next;
  logic [CW-1:0]      run_errs_reg, run_errs_next;
  logic [CW-1:0]      epoch_errs_reg, epoch_errs_next;
  logic [5:0]         w0_reg, w0_next, w1_reg, w1_next, w2_reg, w2_next;
  logic               err_reg, err_next;
  logic               conv_reg, conv_next;
  logic [WW-1:0]      wd_reg;

  logic [5:0]    rd_x1, rd_x2;
  logic          rd_label;
  logic [CW-1:0] errs_now;
  logic          zero_work, last_sample, last_epoch;

  perceptron_sample_mem #(.MAX_SAMPLES(MAX_SAMPLES)) u_mem (
    .clk      (clk),
    .wr_en    (wr_en && !busy),
    .wr_addr  (wr_addr),
    .wr_x1    (wr_x1),
    .wr_x2    (wr_x2),
    .wr_label (wr_label),
    .rd_addr  (idx_reg),
    .rd_x1    (rd_x1),
    .rd_x2    (rd_x2),
    .rd_label (rd_label)
  );

  assign zero_work   = (num_samples == '0) || (num_epochs == '0);
  assign last_sample = ({1'b0, idx_reg} + CW'(1)) == num_samples;
  assign last_epoch  = (epoch_reg + EPOCH_W'(1)) == num_epochs;

  always_comb begin
    state_next      = state_reg;
    loaded_next     = loaded_reg;
    idx_next        = idx_reg;
    epoch_next      = epoch_reg;
    run_errs_next   = run_errs_reg;
    epoch_errs_next = epoch_errs_reg;
    w0_next         = w0_reg;
    w1_next         = w1_reg;
    w2_next         = w2_reg;
    err_next        = err_reg;
    conv_next       = conv_reg;
    errs_now        = run_errs_reg + CW'(p.p_class != rd_label);
    p.p_go          = 1'b0;
    p.p_update      = 1'b0;
    p.p_correct     = 1'b0;
    p.p_sel_out     = SEL_W0;
    p.p_in_val      = '0;
    run_done        = 1'b0;

    case (state_reg)
      IDLE: if (start) begin
        idx_next        = '0;
        epoch_next      = '0;
        run_errs_next   = '0;
        epoch_errs_next = '0;
        err_next        = 1'b0;
        conv_next       = 1'b0;
        // A loaded core keeps its weights; training resumes from them.
        if (!loaded_reg)    state_next = LD_W0;
        else if (zero_work) state_next = RD_W0;
        else                state_next = SX1;
      end
      LD_W0: begin
        p.p_go = 1'b1; p.p_in_val = w0_init;
        if (p.p_sync) state_next = LD_W1;
      end
      LD_W1: begin
        p.p_go = 1'b1; p.p_in_val = w1_init;
        if (p.p_sync) state_next = LD_W2;
      end
      LD_W2: begin
        p.p_go = 1'b1; p.p_in_val = w2_init;
        if (p.p_sync) state_next = LD_N;
      end
      LD_N: begin
        p.p_go = 1'b1; p.p_in_val = n_rate;
        if (p.p_sync) begin
          loaded_next = 1'b1;
          state_next  = zero_work ? RD_W0 : SX1;
        end
      end
      SX1: begin
        p.p_go = 1'b1; p.p_in_val = rd_x1;
        if (p.p_sync) state_next = SX2;
      end
      // The core takes x2 on the cycle after x1 without a sync.
      SX2: begin
        p.p_go = 1'b1; p.p_in_val = rd_x2;
        p.p_update = 1'b1; p.p_correct = rd_label;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        p.p_update = 1'b1; p.p_correct = rd_label;
        if (p.p_done) begin
          if (last_sample) begin
            idx_next        = '0;
            run_errs_next   = '0;
            epoch_errs_next = errs_now;
            epoch_next      = epoch_reg + EPOCH_W'(1);
            state_next      = last_epoch ? RD_W0 : SX1;
`ifdef PERCEPTRON_HOST_EARLY_STOP_EN
            if (errs_now == '0) begin
              conv_next  = 1'b1;
              state_next = RD_W0;
            end
`endif
          end else begin
            idx_next      = idx_reg + AW'(1);
            run_errs_next = errs_now;
            state_next    = SX1;
          end
        end
      end
      RD_W0: begin
        p.p_sel_out = SEL_W0; w0_next = p.p_out_val; state_next = RD_W1;
      end
      RD_W1: begin
        p.p_sel_out = SEL_W1; w1_next = p.p_out_val; state_next = RD_W2;
      end
      RD_W2: begin
        p.p_sel_out = SEL_W2; w2_next = p.p_out_val; state_next = FINISH;
      end
      FINISH: begin
        run_done   = 1'b1;
        state_next = IDLE;
      end
      ERR:     p.p_sel_out = SEL_SUM;
      default: state_next  = IDLE;
    endcase

    // Watchdog: a wait state that has made no progress for TIMEOUT cycles.
    if (is_watched(state_reg) && (state_next == state_reg) &&
        (wd_reg == WW'(TIMEOUT - 1))) begin
      state_next = ERR;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg      <= IDLE;
      loaded_reg     <= 1'b0;
      idx_reg        <= '0;
      epoch_reg      <= '0;
      run_errs_reg   <= '0;
      epoch_errs_reg <= '0;
      w0_reg         <= '0;
      w1_reg         <= '0;
      w2_reg         <= '0;
      err_reg        <= 1'b0;
      conv_reg       <= 1'b0;
      wd_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      loaded_reg     <= loaded_next;
      idx_reg        <= idx_next;
      epoch_reg      <= epoch_next;
      run_errs_reg   <= run_errs_next;
      epoch_errs_reg <= epoch_errs_next;
      w0_reg         <= w0_next;
      w1_reg         <= w1_next;
      w2_reg         <= w2_next;
      err_reg        <= err_next;
      conv_reg       <= conv_next;
      wd_reg         <= (state_next != state_reg) ? '0 : wd_reg + WW'(1);
    end
  end

  assign busy       = (state_reg != IDLE) && (state_reg != ERR);
  assign err        = err_reg;
  assign epoch_errs = epoch_errs_reg;
  assign w0_out     = w0_reg;
  assign w1_out     = w1_reg;
  assign w2_out     = w2_reg;
`ifdef PERCEPTRON_HOST_EARLY_STOP_EN
  assign converged  = conv_reg;
`else
  logic unused_conv;
  assign unused_conv = conv_reg;
`endif
endmodule

// File: tb/tb_perceptron_host.sv
// Bench for perceptron_host with a behavioural perceptron core model.
// Expected run results are queued when a run is issued; a monitor pops and
// compares them whenever run_done is seen.
module tb_perceptron_host;
  import perceptron_host_pkg::*;

`ifdef PERCEPTRON_HOST_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       start = 1'b0;
  logic [5:0] w0_init = '0, w1_init = '0, w2_init = '0, n_rate = '0;
  logic [3:0] num_samples = '0;
  logic [3:0] num_epochs = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [5:0] wr_x1 = '0, wr_x2 = '0;
  logic       wr_label = 1'b0;
  logic       busy, run_done, err;
  logic [3:0] epoch_errs;
  logic [5:0] w0_out, w1_out, w2_out;
  logic       converged;

  perceptron_host_if p();

  perceptron_host dut (
    .clk(clk), .reset_l(reset_l), .start(start),
    .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init), .n_rate(n_rate),
    .num_samples(num_samples), .num_epochs(num_epochs),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_label(wr_label),
    .busy(busy), .run_done(run_done), .err(err), .epoch_errs(epoch_errs),
    .w0_out(w0_out), .w1_out(w1_out), .w2_out(w2_out),
`ifdef PERCEPTRON_HOST_EARLY_STOP_EN
    .converged(converged),
`endif
    .p(p)
  );
`ifndef PERCEPTRON_HOST_EARLY_STOP_EN
  assign converged = 1'b0;
`endif

  always #5 clk = ~clk;

  // ---------------- behavioural perceptron core ----------------
  typedef enum logic [2:0] {C_LD, C_X1, C_X2, C_CALC, C_DONE} core_t;
  core_t            cst;
  logic [1:0]       ld_cnt, calc_cnt;
  logic [5:0]       cw0, cw1, cw2, cn, cx1, cx2;
  logic             stub_nosync = 1'b0;
  logic signed [7:0] sum;

  function automatic logic [5:0] mulq(input logic [5:0] a, input logic [5:0] b);
    logic signed [11:0] pr;
    pr = $signed({{6{a[5]}}, a}) * $signed({{6{b[5]}}, b});
    pr = pr >>> 3;
    return pr[5:0];
  endfunction

  always_comb begin
    logic [5:0] m1, m2;
    m1  = mulq(cw1, cx1);
    m2  = mulq(cw2, cx2);
    sum = $signed({{2{cw0[5]}}, cw0}) + $signed({{2{m1[5]}}, m1}) + $signed({{2{m2[5]}}, m2});
    p.p_sync  = !stub_nosync && p.p_go && (cst == C_LD || cst == C_X1);
    p.p_done  = (cst == C_DONE);
    p.p_class = (sum > 0);
    case (p.p_sel_out)
      2'd3:    p.p_out_val = cw0;
      2'd2:    p.p_out_val = cw1;
      2'd1:    p.p_out_val = cw2;
      default: p.p_out_val = sum[5:0];
    endcase
  end

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cst <= C_LD; ld_cnt <= '0; calc_cnt <= '0;
      cw0 <= '0; cw1 <= '0; cw2 <= '0; cn <= '0; cx1 <= '0; cx2 <= '0;
    end else begin
      case (cst)
        C_LD: if (p.p_go && p.p_sync) begin
          case (ld_cnt)
            2'd0: cw0 <= p.p_in_val;
            2'd1: cw1 <= p.p_in_val;
            2'd2: cw2 <= p.p_in_val;
            default: cn <= p.p_in_val;
          endcase
          ld_cnt <= ld_cnt + 2'd1;
          if (ld_cnt == 2'd3) cst <= C_X1;
        end
        C_X1: if (p.p_go && p.p_sync) begin cx1 <= p.p_in_val; cst <= C_X2; end
        C_X2: begin cx2 <= p.p_in_val; calc_cnt <= '0; cst <= C_CALC; end
        C_CALC: begin
          calc_cnt <= calc_cnt + 2'd1;
          if (calc_cnt == 2'd2) cst <= C_DONE;
        end
        default: begin
          if (p.p_update && (p.p_class != p.p_correct)) begin
            if (p.p_correct) begin
              cw0 <= cw0 + cn; cw1 <= cw1 + mulq(cn, cx1); cw2 <= cw2 + mulq(cn, cx2);
            end else begin
              cw0 <= cw0 - cn; cw1 <= cw1 - mulq(cn, cx1); cw2 <= cw2 - mulq(cn, cx2);
            end
          end
          cst <= C_X1;
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int w0, w1, w2, eerrs, dones, x2go, first_go, conv;
  } exp_t;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   run_no = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int   mon_dones, mon_x2go, mon_overlap, mon_first;
  bit   mon_first_seen;

  always @(negedge clk) begin
    if (start && !busy && !err) begin
      mon_dones = 0; mon_x2go = 0; mon_overlap = 0; mon_first = -1; mon_first_seen = 0;
    end else begin
      if (p.p_done) mon_dones++;
      if (p.p_go && p.p_update) mon_x2go++;
      if (p.p_go && p.p_done) mon_overlap++;
      if (p.p_go && !mon_first_seen) begin
        mon_first = int'(p.p_in_val); mon_first_seen = 1;
      end
    end
    if (run_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_run_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        run_no++;
        $display("run %0d: w=%0d,%0d,%0d epoch_errs=%0d dones=%0d x2go=%0d first_go=%0d err=%0d conv=%0d",
                 run_no, w0_out, w1_out, w2_out, epoch_errs, mon_dones, mon_x2go, mon_first, err, converged);
        check("w0_out", int'(w0_out), e.w0);
        check("w1_out", int'(w1_out), e.w1);
        check("w2_out", int'(w2_out), e.w2);
        check("epoch_errs", int'(epoch_errs), e.eerrs);
        check("done_pulses", mon_dones, e.dones);
        check("x2_go_cycles", mon_x2go, e.x2go);
        check("first_go_val", mon_first, e.first_go);
        check("go_during_done", mon_overlap, 0);
        check("err_after_run", int'(err), 0);
        check("converged", int'(converged), e.conv);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
  endtask

  task automatic wr(input int a, input logic [5:0] x1, input logic [5:0] x2, input logic lab);
    wr_en = 1'b1; wr_addr = 3'(a); wr_x1 = x1; wr_x2 = x2; wr_label = lab;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic run(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                     input logic [5:0] n, input int ns, input int ne, input exp_t e);
    bit seen;
    w0_init = a0; w1_init = a1; w2_init = a2; n_rate = n;
    num_samples = 4'(ns); num_epochs = 4'(ne);
    sb_q.push_back(e);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (run_done) seen = 1;
    end
    check("run_completes", int'(seen), 1);
    if (!seen) sb_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_run_done", int'(run_done), 0);
    check("rst_err", int'(err), 0);
    check("rst_sel_out", int'(p.p_sel_out), 3);
    check("rst_go", int'(p.p_go), 0);
    check("rst_epoch_errs", int'(epoch_errs), 0);
    @(posedge clk); #1 reset_l = 1'b1;

    wr(0, 6'd8, 6'd8, 1'b1);
    wr(1, 6'b111000, 6'b111000, 1'b0);

    // zero-epoch run: load then read back the initial weights
    e = '{w0:0, w1:8, w2:8, eerrs:0, dones:0, x2go:0, first_go:0, conv:0};
    run(6'd0, 6'd8, 6'd8, 6'd8, 2, 0, e);

    // one sample, one epoch from zero weights: one misclassification
    do_reset();
    e = '{w0:8, w1:8, w2:8, eerrs:1, dones:1, x2go:1, first_go:0, conv:0};
    run(6'd0, 6'd0, 6'd0, 6'd8, 1, 1, e);

    // two samples, three epochs (converges after the second epoch)
    do_reset();
    e = '{w0:8, w1:8, w2:8, eerrs:0, dones:(EARLY ? 4 : 6), x2go:(EARLY ? 4 : 6),
          first_go:0, conv:(EARLY ? 1 : 0)};
    run(6'd0, 6'd0, 6'd0, 6'd8, 2, 3, e);

    // second start without reset: no reload, first go carries x1[0]
    e = '{w0:8, w1:8, w2:8, eerrs:0, dones:2, x2go:2, first_go:8, conv:(EARLY ? 1 : 0)};
    run(6'd5, 6'd5, 6'd5, 6'd8, 2, 1, e);

    // fifteen epochs on a separable set
    do_reset();
    e = '{w0:8, w1:8, w2:8, eerrs:0, dones:(EARLY ? 4 : 30), x2go:(EARLY ? 4 : 30),
          first_go:0, conv:(EARLY ? 1 : 0)};
    run(6'd0, 6'd0, 6'd0, 6'd8, 2, 15, e);

    // core never syncs: watchdog must trip in LD_W0
    do_reset();
    stub_nosync = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(negedge clk);
    check("wd_err_early", int'(err), 0);
    check("wd_busy_early", int'(busy), 1);
    repeat (20) @(negedge clk);
    check("wd_err", int'(err), 1);
    check("wd_busy", int'(busy), 0);
    check("wd_go_low", int'(p.p_go), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_ignores_start", int'(busy), 0);
    reset_l = 1'b0;
    #1;
    check("rst_clears_err", int'(err), 0);
    check("rst_busy_after_err", int'(busy), 0);
    stub_nosync = 1'b0;
    @(posedge clk); #1 reset_l = 1'b1;
    repeat (2) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
